// File: rtl/sig_unpack_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sig_unpack_pipe_pkg
// Shared FPU format constants used by the significand unpack pipeline.
//   FPU_FW   : double-precision fraction width
//   FPU_SFW  : single-precision fraction width
//   FPU_SOFF : bit position of the single fraction LSB inside the packed operand
//   FPU_LZW  : width of a leading-zero count covering FW+1 bits (2**LZW > FW+1)
// -----------------------------------------------------------------------------
package sig_unpack_pipe_pkg;

   localparam int FPU_FW   = 52;
   localparam int FPU_SFW  = 23;
   localparam int FPU_SOFF = 32;
   localparam int FPU_LZW  = 6;

endpackage : sig_unpack_pipe_pkg

// File: rtl/sig_unpack_pipe_lzc_shift.sv
// -----------------------------------------------------------------------------
// lzc_shift
// Leading-zero counter and left shifter, kept as two independent paths so the
// count can sit in one pipeline stage and the shift in the next.
// Ports:
//   cnt_i  [W-1:0]   value whose leading zeros are counted (MSB first)
//   lz_o   [LZW-1:0] leading-zero count; equals W when cnt_i is zero
//   sh_i   [W-1:0]   value to shift left
//   amt_i  [LZW-1:0] shift amount
//   sh_o   [W-1:0]   sh_i << amt_i, zero fill, truncated to W bits
// -----------------------------------------------------------------------------
module lzc_shift #(
   parameter int W   = 53,
   parameter int LZW = 6
) (
   input  logic [W-1:0]   cnt_i,
   output logic [LZW-1:0] lz_o,
   input  logic [W-1:0]   sh_i,
   input  logic [LZW-1:0] amt_i,
   output logic [W-1:0]   sh_o
);

   // Scan LSB to MSB so the last hit is the most significant set bit.
   always_comb begin
      lz_o = LZW'(W);
      for (int i = 0; i < W; i++) begin
         if (cnt_i[i]) begin
            lz_o = LZW'(W - 1 - i);
         end
      end
   end

   assign sh_o = sh_i << amt_i;

endmodule : lzc_shift

// File: rtl/sig_unpack_pipe.sv
// -----------------------------------------------------------------------------
// sig_unpack_pipe
// Two-stage pipeline that extracts the fraction of a single or double operand,
// prepends the hidden bit, counts leading zeros and optionally normalises.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (transfer when both high)
//   db                  1 = double, 0 = single
//   x      [FW+11:0]    packed operand
//   e_z                 exponent is zero (hidden bit = 0)
//   normal              1 = left-justify the significand
//   out_valid/out_ready output handshake (transfer when both high)
//   f      [FW:0]       significand including hidden bit
//   lz     [LZW-1:0]    leading-zero count of the significand
//   fz                  raw fraction is zero
//   h      [FW-1:0]     raw fraction
// -----------------------------------------------------------------------------
module sig_unpack_pipe
   import sig_unpack_pipe_pkg::*;
#(
   parameter int FW   = FPU_FW,
   parameter int SFW  = FPU_SFW,
   parameter int SOFF = FPU_SOFF,
   parameter int LZW  = FPU_LZW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           db,
   input  logic [FW+11:0] x,
   input  logic           e_z,
   input  logic           normal,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [FW:0]    f,
   output logic [LZW-1:0] lz,
   output logic           fz,
   output logic [FW-1:0]  h
);

   logic           vld_p1_q, vld_p1_d;
   logic           vld_p2_q, vld_p2_d;
   logic           adv_p1, adv_p2, acc_p0;

   logic [FW-1:0]  h_p0;
   logic [FW:0]    te_p0;
   logic [LZW-1:0] lz_p0;
   logic           fz_p0;

   logic [FW-1:0]  h_p1_q;
   logic [FW:0]    te_p1_q;
   logic [LZW-1:0] lz_p1_q;
   logic           fz_p1_q;
   logic           nrm_p1_q;
   logic [FW:0]    sh_p1;
   logic [FW:0]    f_p1;

   logic [FW:0]    f_p2_q;
   logic [LZW-1:0] lz_p2_q;
   logic           fz_p2_q;
   logic [FW-1:0]  h_p2_q;

   // Exponent/sign bits above the fraction never influence this block.
   logic           unused_x_hi;
   assign unused_x_hi = ^x[FW+11:FW];

   // ---- handshake control --------------------------------------------------
   always_comb begin
      adv_p2   = !vld_p2_q || out_ready;
      adv_p1   = vld_p1_q && adv_p2;
      in_ready = !rst && (!vld_p1_q || adv_p2);
      acc_p0   = in_valid && in_ready;
      vld_p1_d = acc_p0 || (vld_p1_q && !adv_p1);
      vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
      end
   end

   // ---- stage 0: field select, hidden bit, leading-zero count --------------
   assign h_p0  = db ? x[FW-1:0] : {x[SOFF+SFW-1:SOFF], {(FW-SFW){1'b0}}};
   assign te_p0 = {~e_z, h_p0};
   assign fz_p0 = (h_p0 == '0);

   // Count runs on the stage-0 operand; shift runs on the stage-1 registers.
   lzc_shift #(
      .W   (FW + 1),
      .LZW (LZW)
   ) u_lzc_shift (
      .cnt_i (te_p0),
      .lz_o  (lz_p0),
      .sh_i  (te_p1_q),
      .amt_i (lz_p1_q),
      .sh_o  (sh_p1)
   );

   // ---- stage 1 register ---------------------------------------------------
   always_ff @(posedge clk) begin
      if (acc_p0) begin
         h_p1_q   <= h_p0;
         te_p1_q  <= te_p0;
         lz_p1_q  <= lz_p0;
         fz_p1_q  <= fz_p0;
         nrm_p1_q <= normal;
      end
   end

   assign f_p1 = nrm_p1_q ? sh_p1 : te_p1_q;

   // ---- stage 2 register (outputs) -----------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         f_p2_q  <= '0;
         lz_p2_q <= '0;
         fz_p2_q <= 1'b0;
         h_p2_q  <= '0;
      end else if (adv_p1) begin
         f_p2_q  <= f_p1;
         lz_p2_q <= lz_p1_q;
         fz_p2_q <= fz_p1_q;
         h_p2_q  <= h_p1_q;
      end
   end

   assign out_valid = vld_p2_q;
   assign f         = f_p2_q;
   assign lz        = lz_p2_q;
   assign fz        = fz_p2_q;
   assign h         = h_p2_q;

endmodule : sig_unpack_pipe

// File: tb/tb_sig_unpack_pipe.sv
module tb_sig_unpack_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        db = 1'b0;
   logic        e_z = 1'b0;
   logic        normal = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] x = '0;
   logic        in_ready, out_valid, fz;
   logic [52:0] f;
   logic [5:0]  lz;
   logic [51:0] h;

   always #5 clk = ~clk;

   sig_unpack_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .db        (db),
      .x         (x),
      .e_z       (e_z),
      .normal    (normal),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f         (f),
      .lz        (lz),
      .fz        (fz),
      .h         (h)
   );

   typedef struct packed {
      logic [52:0] f;
      logic [5:0]  lz;
      logic        fz;
      logic [51:0] h;
   } res_t;

   typedef struct packed {
      logic        db;
      logic        ez;
      logic        nrm;
      logic [63:0] x;
      res_t        r;
   } vec_t;

   res_t sb_q[$];
   vec_t vecs[11];
   int   checks = 0;
   int   failures = 0;
   int   occ = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endfunction

   // Bench-side occupancy model: operands accepted but not yet delivered.
   always @(posedge clk) begin
      if (rst) occ <= 0;
      else occ <= occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
   end

   // Monitor: compare the presented result against the scoreboard head every
   // cycle it is valid (covers hold-stability during stalls), pop on transfer.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", {63'd0, in_ready}, {63'd0, !(occ == 2 && !out_ready)});
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
               chk("f",  {11'd0, f},  {11'd0, sb_q[0].f});
               chk("lz", {58'd0, lz}, {58'd0, sb_q[0].lz});
               chk("fz", {63'd0, fz}, {63'd0, sb_q[0].fz});
               chk("h",  {12'd0, h},  {12'd0, sb_q[0].h});
               if (out_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic send(input vec_t v);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      in_valid = 1'b1;
      db = v.db;
      e_z = v.ez;
      normal = v.nrm;
      x = v.x;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back(v.r);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout waited=%0d cycles required<=50", n);
            done = 1'b1;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_pending", sb_q.size(), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{db:1'b1, ez:1'b0, nrm:1'b1, x:64'h0008_0000_0000_0000,
                   r:'{f:53'h18000000000000, lz:6'd0,  fz:1'b0, h:52'h8000000000000}};
      vecs[1]  = '{db:1'b1, ez:1'b1, nrm:1'b1, x:64'h0000_0000_0000_0001,
                   r:'{f:53'h10000000000000, lz:6'd52, fz:1'b0, h:52'h1}};
      vecs[2]  = '{db:1'b1, ez:1'b1, nrm:1'b0, x:64'h0000_0000_0000_0001,
                   r:'{f:53'h1,              lz:6'd52, fz:1'b0, h:52'h1}};
      vecs[3]  = '{db:1'b0, ez:1'b1, nrm:1'b1, x:64'hFF80_0000_FFFF_FFFF,
                   r:'{f:53'h0,              lz:6'd53, fz:1'b1, h:52'h0}};
      vecs[4]  = '{db:1'b0, ez:1'b1, nrm:1'b1, x:64'h0040_0000_0000_0000,
                   r:'{f:53'h10000000000000, lz:6'd1,  fz:1'b0, h:52'h8000000000000}};
      vecs[5]  = '{db:1'b1, ez:1'b0, nrm:1'b0, x:64'hABC0_0123_4567_89AB,
                   r:'{f:53'h100123456789AB, lz:6'd0,  fz:1'b0, h:52'h00123456789AB}};
      vecs[6]  = '{db:1'b1, ez:1'b1, nrm:1'b1, x:64'hABC0_0123_4567_89AB,
                   r:'{f:53'h123456789AB000, lz:6'd12, fz:1'b0, h:52'h00123456789AB}};
      vecs[7]  = '{db:1'b0, ez:1'b0, nrm:1'b1, x:64'h007F_FFFF_0000_0000,
                   r:'{f:53'h1FFFFFE0000000, lz:6'd0,  fz:1'b0, h:52'hFFFFFE0000000}};
      vecs[8]  = '{db:1'b0, ez:1'b1, nrm:1'b1, x:64'h0000_0001_0000_0000,
                   r:'{f:53'h10000000000000, lz:6'd23, fz:1'b0, h:52'h0000020000000}};
      vecs[9]  = '{db:1'b1, ez:1'b1, nrm:1'b1, x:64'hFFF0_0000_0001_0000,
                   r:'{f:53'h10000000000000, lz:6'd36, fz:1'b0, h:52'h0000000010000}};
      vecs[10] = '{db:1'b1, ez:1'b1, nrm:1'b0, x:64'h0,
                   r:'{f:53'h0,              lz:6'd53, fz:1'b1, h:52'h0}};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
      chk("rst_f",  {11'd0, f},  64'd0);
      chk("rst_lz", {58'd0, lz}, 64'd0);
      chk("rst_fz", {63'd0, fz}, 64'd0);
      chk("rst_h",  {12'd0, h},  64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Full-throughput directed vectors
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) send(vecs[i]);
      drain();

      // Eight back-to-back operands with out_ready pattern 1,0,0,1
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               out_ready = (k % 4 == 0) || (k % 4 == 3);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 8; i++) send(vecs[i]);
            in_valid = 1'b0;
         end
      join
      drain();

      // Mid-operation reset with both stages full
      out_ready = 1'b0;
      send(vecs[5]);
      send(vecs[6]);
      in_valid = 1'b0;
      chk("full_out_valid", {63'd0, out_valid}, 64'd1);
      chk("full_in_ready",  {63'd0, in_ready},  64'd0);
      rst = 1'b1;
      sb_q.delete();
      @(posedge clk);
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_in_ready",  {63'd0, in_ready},  64'd0);
      chk("midrst_f", {11'd0, f}, 64'd0);
      chk("midrst_h", {12'd0, h}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_stale_out", {63'd0, out_valid}, 64'd0);
      end

      // One more operand after reset to confirm the pipe restarts cleanly
      send(vecs[4]);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sig_unpack_pipe

// File: doc/sig_unpack_pipe.md
SIG_UNPACK_PIPE -- requirements
Module: sig_unpack_pipe

Interface
REQ-001 SHALL have parameter FW, default 52, double fraction width.
REQ-002 SHALL have parameter SFW, default 23, single fraction width.
REQ-003 SHALL have parameter SOFF, default 32, bit position of the single fraction LSB within x.
REQ-004 SHALL have parameter LZW, default 6, width of lz; SHALL satisfy 2**LZW > FW+1.
REQ-005 SHALL provide clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-007 SHALL provide in_valid  input  1  operand present; in_ready  output  1  operand accepted when both high.
REQ-008 SHALL provide db  input  1  1 = double, 0 = single.
REQ-009 SHALL provide x  input  FW+12  packed operand; e_z  input  1  exponent zero; normal  input  1  normalise request.
REQ-010 SHALL provide out_valid  output  1; out_ready  input  1; transfer when both high.
REQ-011 SHALL provide f  output  FW+1  significand incl. hidden bit; lz  output  LZW  leading-zero count; fz  output  1  fraction zero; h  output  FW  raw fraction.

Function
REQ-012 SHALL form h = x[FW-1:0] when db=1, else {x[SOFF+SFW-1:SOFF], (FW-SFW) zeros}.
REQ-013 SHALL form te = {~e_z, h}; fz = 1 iff h == 0.
REQ-014 SHALL set lz = count of leading zeros of te, MSB first; lz = FW+1 when te == 0.
REQ-015 SHALL output f = te << lz, zero fill, truncated to FW+1 bits, when normal=1; f = te when normal=0.
REQ-016 SHALL be a two-stage pipeline: S1 registers h, te, fz, lz, normal; S2 registers f, lz, fz, h.
REQ-017 SHALL have latency 2 cycles from an accepted input to out_valid, with no bubbles at full throughput.
REQ-018 SHALL accept one operand per cycle when out_ready is held high.
REQ-019 SHALL advance S2 when S2 is empty or out_ready=1.
REQ-020 SHALL advance S1 into S2 when S1 is valid and S2 advances.
REQ-021 SHALL drive in_ready = S1 empty or S1 advancing; in_ready SHALL NOT depend combinationally on in_valid.
REQ-022 SHALL hold all output data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL NOT capture input when in_valid=0; stage valid bits SHALL clear when a stage drains without refill.
REQ-024 SHALL, on simultaneous S2 output and S1 refill in the same cycle, transfer both without loss or duplication.
REQ-025 SHALL ignore x bits outside the selected fraction field.

Reset
REQ-026 SHALL, while rst=1, clear both stage valid bits, out_valid=0, f=0, lz=0, fz=0, h=0.
REQ-027 SHALL drive in_ready=0 while rst=1 and in_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL discard in-flight operands on mid-operation reset; none SHALL emerge afterwards.

Structure
REQ-029 SHALL take FW, SFW, SOFF and LZW defaults from the shared fpu package constants.
REQ-030 SHALL implement the count and shift as sub-module lzc_shift (parametrised leading-zero counter plus left shifter), instantiated in S1/S2.
REQ-031 SHALL be free of latches; all sequential logic SHALL use clk only.

Verification
REQ-032 SHALL verify: db=1, e_z=0, normal=1, x[51:0]=0x8000000000000 -> after 2 cycles f=0x18000000000000, lz=0, fz=0.
REQ-033 SHALL verify: db=1, e_z=1, normal=1, x[51:0]=1 -> f=0x10000000000000, lz=52, fz=0; with normal=0 -> f=1.
REQ-034 SHALL verify: db=0, e_z=1, x[54:32]=0, normal=1 -> h=0, fz=1, lz=53, f=0.
REQ-035 SHALL verify: 8 back-to-back operands with out_ready toggling 1,0,0,1 -> all 8 emerge in order, data stable during stall, in_ready=0 only when both stages are full and out_ready=0.
REQ-036 SHALL verify: rst asserted with both stages full -> out_valid=0 the next cycle, no stale result after release.
REQ-037 SHALL verify: db=0, x[54:32]=0x400000, e_z=1, normal=1 -> h=0x8000000000000, lz=1, f=0x10000000000000.
